// File: rtl/fifo_s2b_pkg.sv
// Shared constants and elaboration-time helpers for the narrow-to-wide packet CDC.
// Entry layout in the FIFO is {data, keep, last}.
package fifo_s2b_pkg;

    localparam int AF_MARGIN_DEF = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int entry_w(input int dw_in, input int ratio);
        return dw_in * ratio + ratio + 1;
    endfunction

endpackage

// File: rtl/afifo_gray.sv
// Generic dual-clock FIFO with Gray pointers, 2-flop synchronisers, show-ahead read data.
// Write-side level includes the current write so callers can register a ready flag with no lag.
module afifo_gray #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          wr_clk,
    input  logic          wr_rstn,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_dat_i,
    output logic          wr_full_o,
    output logic [AW:0]   wr_lvl_nxt_o,
    input  logic          rd_clk,
    input  logic          rd_rstn,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_dat_o,
    output logic          rd_empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wbin_q, wbin_d, wgray_q, rq1_q, rq2_q;
    logic [AW:0]   rbin_q, rbin_d, rgray_q, wq1_q, wq2_q;
    logic          wr_go, rd_go;

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    // Full: pointers equal except the two MSBs, which differ after one wrap.
    assign wr_full_o    = (wgray_q == {~rq2_q[AW:AW-1], rq2_q[AW-2:0]});
    assign wr_go        = wr_en_i & ~wr_full_o;
    assign wbin_d       = wbin_q + (AW+1)'(wr_go);
    assign wr_lvl_nxt_o = wbin_d - gray2bin(rq2_q);

    always_ff @(posedge wr_clk) begin
        if (wr_go) mem_q[wbin_q[AW-1:0]] <= wr_dat_i;
    end

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            rq1_q   <= '0;
            rq2_q   <= '0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= bin2gray(wbin_d);
            rq1_q   <= rgray_q;
            rq2_q   <= rq1_q;
        end
    end

    assign rd_empty_o = (rgray_q == wq2_q);
    assign rd_go      = rd_en_i & ~rd_empty_o;
    assign rbin_d     = rbin_q + (AW+1)'(rd_go);
    assign rd_dat_o   = mem_q[rbin_q[AW-1:0]];

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            wq1_q   <= '0;
            wq2_q   <= '0;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= bin2gray(rbin_d);
            wq1_q   <= wgray_q;
            wq2_q   <= wq1_q;
        end
    end

endmodule

// File: rtl/fifo_s2b_pkt_packer.sv
// Assembles RATIO narrow beats into one word plus arrival-order keep mask.
// Push strobe is combinational with the closing beat; beats are only taken when din_rdy_i is high.
module s2b_packer
    import fifo_s2b_pkg::*;
#(
    parameter int  DW_IN     = 4,
    parameter int  RATIO     = 4,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int DW_OUT    = DW_IN * RATIO,
    localparam int CW        = clog2(RATIO)
) (
    input  logic              din_clk,
    input  logic              rstn,
    input  logic [DW_IN-1:0]  din_i,
    input  logic              din_en_i,
    input  logic              din_last_i,
    input  logic              din_rdy_i,
    output logic              push_o,
    output logic [DW_OUT-1:0] word_dat_o,
    output logic [RATIO-1:0]  word_keep_o,
    output logic              word_last_o
);
    logic [CW-1:0]     cnt_q, cnt_d, lane;
    logic [DW_OUT-1:0] dat_q, dat_d, lane_dat;
    logic [RATIO-1:0]  keep_q, keep_d, lane_keep;
    logic              accept;

    assign accept    = din_en_i & din_rdy_i;
    // Physical lane differs from arrival index only in MSB-first order.
    assign lane      = MSB_FIRST ? CW'(RATIO - 1) - cnt_q : cnt_q;
    assign lane_dat  = DW_OUT'(din_i) << (lane * DW_IN);
    assign lane_keep = RATIO'(1) << cnt_q;

    always_comb begin
        word_dat_o  = dat_q | lane_dat;
        word_keep_o = keep_q | lane_keep;
        word_last_o = din_last_i;
        push_o      = accept & (din_last_i | (cnt_q == CW'(RATIO - 1)));
        cnt_d       = cnt_q;
        dat_d       = dat_q;
        keep_d      = keep_q;
        if (push_o) begin
            cnt_d  = '0;
            dat_d  = '0;
            keep_d = '0;
        end else if (accept) begin
            cnt_d  = cnt_q + 1'b1;
            dat_d  = word_dat_o;
            keep_d = word_keep_o;
        end
    end

    always_ff @(posedge din_clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            dat_q  <= '0;
            keep_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dat_q  <= dat_d;
            keep_q <= keep_d;
        end
    end

endmodule

// File: rtl/fifo_s2b_pkt.sv
// Narrow-to-wide packet CDC: packer in din_clk, async FIFO, one-entry valid/ready output register.
// Push-to-dout_vld 3-4 dout_clk; din_rdy drops with AF_MARGIN headroom, dout holds while stalled.
module fifo_s2b_pkt
    import fifo_s2b_pkg::*;
#(
    parameter int  DW_IN     = 4,
    parameter int  RATIO     = 4,
    parameter int  AW        = 3,
    parameter bit  MSB_FIRST = 1'b1,
    parameter int  AF_MARGIN = AF_MARGIN_DEF,
    localparam int DW_OUT    = DW_IN * RATIO
) (
    input  logic              rstn,
    input  logic              dout_clk,
    input  logic              din_clk,
    input  logic [DW_IN-1:0]  din,
    input  logic              din_en,
    input  logic              din_last,
    output logic              din_rdy,
    output logic              ovf,
    output logic [DW_OUT-1:0] dout,
    output logic [RATIO-1:0]  dout_keep,
    output logic              dout_last,
    output logic              dout_vld,
    input  logic              dout_rdy
);
    localparam int EW    = entry_w(DW_IN, RATIO);
    localparam int DEPTH = 1 << AW;

    logic              push, wr_full, rd_empty, pop;
    logic [DW_OUT-1:0] pk_dat;
    logic [RATIO-1:0]  pk_keep;
    logic              pk_last;
    logic [EW-1:0]     rd_dat;
    logic [AW:0]       wr_lvl_nxt, free_nxt;
    logic              din_rdy_q, din_rdy_d, ovf_q, ovf_d;
    logic [DW_OUT-1:0] dout_q, dout_d;
    logic [RATIO-1:0]  keep_q, keep_d;
    logic              last_q, last_d, vld_q, vld_d;

    s2b_packer #(
        .DW_IN     (DW_IN),
        .RATIO     (RATIO),
        .MSB_FIRST (MSB_FIRST)
    ) u_packer (
        .din_clk     (din_clk),
        .rstn        (rstn),
        .din_i       (din),
        .din_en_i    (din_en),
        .din_last_i  (din_last),
        .din_rdy_i   (din_rdy_q),
        .push_o      (push),
        .word_dat_o  (pk_dat),
        .word_keep_o (pk_keep),
        .word_last_o (pk_last)
    );

    afifo_gray #(
        .DW (EW),
        .AW (AW)
    ) u_fifo (
        .wr_clk       (din_clk),
        .wr_rstn      (rstn),
        .wr_en_i      (push),
        .wr_dat_i     ({pk_dat, pk_keep, pk_last}),
        .wr_full_o    (wr_full),
        .wr_lvl_nxt_o (wr_lvl_nxt),
        .rd_clk       (dout_clk),
        .rd_rstn      (rstn),
        .rd_en_i      (pop),
        .rd_dat_o     (rd_dat),
        .rd_empty_o   (rd_empty)
    );

    // Level already counts this cycle's push, so the registered ready never lags a write.
    always_comb begin
        free_nxt  = (AW+1)'(DEPTH) - wr_lvl_nxt;
        din_rdy_d = ~wr_full & (free_nxt > (AW+1)'(AF_MARGIN));
        ovf_d     = ovf_q | (din_en & ~din_rdy_q);
    end

    always_ff @(posedge din_clk or negedge rstn) begin
        if (!rstn) begin
            din_rdy_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            din_rdy_q <= din_rdy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pop = ~rd_empty & (~vld_q | dout_rdy);

    always_comb begin
        vld_d  = vld_q;
        dout_d = dout_q;
        keep_d = keep_q;
        last_d = last_q;
        if (pop) begin
            {dout_d, keep_d, last_d} = rd_dat;
            vld_d = 1'b1;
        end else if (dout_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge dout_clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= 1'b0;
            dout_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            dout_q <= dout_d;
            keep_q <= keep_d;
            last_q <= last_d;
        end
    end

    assign din_rdy   = din_rdy_q;
    assign ovf       = ovf_q;
    assign dout      = dout_q;
    assign dout_keep = keep_q;
    assign dout_last = last_q;
    assign dout_vld  = vld_q;

endmodule

// File: tb/tb_fifo_s2b_pkt.sv
// Scoreboard bench: stimulus pushes expected words, negedge monitors pop and compare.
module tb_fifo_s2b_pkt;

    logic        rstn = 1'b0;
    logic        din_clk = 1'b0;
    logic        dout_clk = 1'b0;
    logic [3:0]  din = '0;
    logic        din_en = 1'b0;
    logic        din_last = 1'b0;
    logic        din_rdy, ovf;
    logic [15:0] dout;
    logic [3:0]  dout_keep;
    logic        dout_last, dout_vld;
    logic        dout_rdy = 1'b0;

    logic        lsb_sel = 1'b0;
    logic        din_en2;
    logic        din_rdy2, ovf2;
    logic [15:0] dout2;
    logic [3:0]  dout_keep2;
    logic        dout_last2, dout_vld2;

    int din_half  = 5;
    int dout_half = 5;
    int n_chk     = 0;
    int n_pass    = 0;
    int beats_acc = 0;
    logic rnd_rdy   = 1'b0;
    logic rdy_force = 1'b1;

    logic [20:0] exp_q[$];
    logic [20:0] exp2_q[$];
    logic [20:0] hold_w;
    logic        stall_prev = 1'b0;
    logic [15:0] w;

    int          m_cnt  = 0;
    logic [15:0] m_dat  = '0;
    logic [3:0]  m_keep = '0;

    assign din_en2 = din_en & lsb_sel;

    fifo_s2b_pkt u_dut (
        .rstn      (rstn),
        .dout_clk  (dout_clk),
        .din_clk   (din_clk),
        .din       (din),
        .din_en    (din_en),
        .din_last  (din_last),
        .din_rdy   (din_rdy),
        .ovf       (ovf),
        .dout      (dout),
        .dout_keep (dout_keep),
        .dout_last (dout_last),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy)
    );

    fifo_s2b_pkt #(.MSB_FIRST(1'b0)) u_lsb (
        .rstn      (rstn),
        .dout_clk  (dout_clk),
        .din_clk   (din_clk),
        .din       (din),
        .din_en    (din_en2),
        .din_last  (din_last),
        .din_rdy   (din_rdy2),
        .ovf       (ovf2),
        .dout      (dout2),
        .dout_keep (dout_keep2),
        .dout_last (dout_last2),
        .dout_vld  (dout_vld2),
        .dout_rdy  (1'b1)
    );

    initial forever #(din_half) din_clk = ~din_clk;
    initial forever #(dout_half) dout_clk = ~dout_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Sink ready: random in the soak phase, otherwise the directed level.
    initial forever begin
        @(posedge dout_clk);
        #1;
        dout_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    always @(negedge dout_clk) begin
        if (!rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) chk("hold", {dout_vld, dout, dout_keep, dout_last}, {1'b1, hold_w});
            if (dout_vld && dout_rdy) begin
                if (exp_q.size() == 0) chk("spare_word", dout_vld, 1'b0);
                else chk("word", {dout, dout_keep, dout_last}, exp_q.pop_front());
            end
            stall_prev = dout_vld && !dout_rdy;
            hold_w     = {dout, dout_keep, dout_last};
        end
    end

    always @(negedge dout_clk) begin
        if (rstn && dout_vld2) begin
            if (exp2_q.size() == 0) chk("lsb_spare_word", dout_vld2, 1'b0);
            else chk("lsb_word", {dout2, dout_keep2, dout_last2}, exp2_q.pop_front());
        end
    end

    task automatic put_beat(input logic [3:0] d, input logic l);
        int guard;
        guard = 0;
        @(negedge din_clk);
        while (!din_rdy && guard < 4000) begin
            @(negedge din_clk);
            guard++;
        end
        if (!din_rdy) begin
            chk("rdy_timeout", din_rdy, 1'b1);
            return;
        end
        din      = d;
        din_last = l;
        din_en   = 1'b1;
        @(posedge din_clk);
        #1;
        din_en   = 1'b0;
        din_last = 1'b0;
        beats_acc++;
    endtask

    task automatic rnd_beat(input logic [3:0] d, input logic l);
        m_dat[15 - 4*m_cnt -: 4] = d;
        m_keep[m_cnt] = 1'b1;
        if (l || m_cnt == 3) begin
            exp_q.push_back({m_dat, m_keep, l});
            m_cnt  = 0;
            m_dat  = '0;
            m_keep = '0;
        end else begin
            m_cnt++;
        end
        put_beat(d, l);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && g < 6000) begin
            @(negedge dout_clk);
            g++;
        end
        chk("drain", exp_q.size() + exp2_q.size(), 0);
        repeat (12) @(negedge dout_clk);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge din_clk);
        #2;
        chk("rst_din_rdy", din_rdy, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_vld", dout_vld, 1'b0);
        chk("rst_dout", dout, 16'h0);
        chk("rst_keep", dout_keep, 4'h0);
        chk("rst_last", dout_last, 1'b0);
        @(negedge din_clk);
        rstn = 1'b1;
        repeat (4) @(negedge din_clk);
        chk("rdy_after_rst", din_rdy, 1'b1);

        // Full word, MSB-first
        exp_q.push_back({16'h1234, 4'b1111, 1'b0});
        put_beat(4'h1, 1'b0);
        put_beat(4'h2, 1'b0);
        put_beat(4'h3, 1'b0);
        put_beat(4'h4, 1'b0);
        wait_drain();

        // Short packet flushed with keep, both lane orders
        exp_q.push_back({16'hAB00, 4'b0011, 1'b1});
        exp2_q.push_back({16'h00BA, 4'b0011, 1'b1});
        lsb_sel = 1'b1;
        put_beat(4'hA, 1'b0);
        put_beat(4'hB, 1'b1);
        lsb_sel = 1'b0;
        // din_last on the first beat, and on the fourth
        exp_q.push_back({16'h7000, 4'b0001, 1'b1});
        put_beat(4'h7, 1'b1);
        exp_q.push_back({16'hCDEF, 4'b1111, 1'b1});
        put_beat(4'hC, 1'b0);
        put_beat(4'hD, 1'b0);
        put_beat(4'hE, 1'b0);
        put_beat(4'hF, 1'b1);
        wait_drain();

        // Stalled sink: 7 words fit (6 in FIFO + output register), then overflow attempt
        rdy_force = 1'b0;
        repeat (3) @(negedge dout_clk);
        for (int k = 0; k < 10; k++) begin
            w = {4'(4*k + 1), 4'(4*k + 2), 4'(4*k + 3), 4'(4*k + 4)};
            exp_q.push_back({w, 4'b1111, 1'b0});
        end
        beats_acc = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) put_beat(4'(i + 1), 1'b0);
            end
            begin
                int g;
                g = 0;
                @(negedge din_clk);
                while (din_rdy && g < 2000) begin
                    @(negedge din_clk);
                    g++;
                end
                chk("rdy_drop", din_rdy, 1'b0);
                chk("beats_at_drop", beats_acc, 28);
                chk("ovf_clean", ovf, 1'b0);
                @(negedge din_clk);
                chk("rdy_low", din_rdy, 1'b0);
                din    = 4'h0;
                din_en = 1'b1;
                @(posedge din_clk);
                #1;
                din_en = 1'b0;
                @(negedge din_clk);
                chk("ovf_set", ovf, 1'b1);
                repeat (10) @(negedge din_clk);
                chk("beats_stalled", beats_acc, 28);
                @(negedge dout_clk);
                rdy_force = 1'b1;
                @(posedge dout_clk);
                #2;
                for (int k = 0; k < 7; k++) begin
                    @(negedge dout_clk);
                    chk("no_gap", dout_vld, 1'b1);
                end
            end
        join
        exp_q.push_back({16'h9ABC, 4'b1111, 1'b0});
        put_beat(4'h9, 1'b0);
        put_beat(4'hA, 1'b0);
        put_beat(4'hB, 1'b0);
        put_beat(4'hC, 1'b0);
        wait_drain();
        chk("ovf_sticky", ovf, 1'b1);

        // Random soak over three clock ratios with random sink stalls
        rnd_rdy = 1'b1;
        for (int p = 0; p < 3; p++) begin
            din_half  = (p == 0) ? 3 : (p == 1) ? 7 : 5;
            dout_half = (p == 0) ? 7 : (p == 1) ? 3 : 5;
            for (int n = 0; n < 3334; n++) begin
                if ($urandom_range(0, 3) == 0) @(posedge din_clk);
                rnd_beat(4'($urandom), (n == 3333) || ($urandom_range(0, 6) == 0));
            end
            wait_drain();
        end
        rnd_rdy   = 1'b0;
        rdy_force = 1'b0;

        // Reset mid-packet with 5 words queued
        @(posedge dout_clk);
        #2;
        for (int i = 0; i < 22; i++) put_beat(4'(i), 1'b0);
        repeat (12) @(negedge dout_clk);
        @(negedge din_clk);
        rstn = 1'b0;
        #3;
        chk("mid_rst_din_rdy", din_rdy, 1'b0);
        chk("mid_rst_ovf", ovf, 1'b0);
        chk("mid_rst_vld", dout_vld, 1'b0);
        chk("mid_rst_dout", {dout, dout_keep, dout_last}, 21'h0);
        repeat (3) @(negedge din_clk);
        rstn      = 1'b1;
        rdy_force = 1'b1;
        repeat (30) @(negedge dout_clk);
        chk("idle_after_rst", dout_vld, 1'b0);
        exp_q.push_back({16'h5678, 4'b1111, 1'b0});
        put_beat(4'h5, 1'b0);
        put_beat(4'h6, 1'b0);
        put_beat(4'h7, 1'b0);
        put_beat(4'h8, 1'b0);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
